kbd_scan_rx: RTL and testbench



---
 rtl/kbd_scan_rx.sv | 81 ++++++++
 tb/tb_kbd_scan_rx.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/kbd_scan_rx.sv
// kbd_scan_rx: PC keyboard serial receiver; assembles a start+8 bit frame, strobes the ls374 pair and holds IRQ1 until ack.
`timescale 1ns/1ps
module kbd_scan_rx #(
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 2000,
    parameter int TW          = 11
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       kbd_clk,
    input  logic       kbd_data,
    input  logic       ack,
    output logic [7:0] code,
    output logic       g,
    output logic       irq,
    output logic       kbd_inhibit,
    output logic       busy
);
    typedef enum logic [1:0] {IDLE, SHIFT, STROBE, HOLD} state_t;
    state_t state, state_nxt;
    logic [SYNC_STAGES-1:0] clk_sync, data_sync;
    logic clk_prev;
    logic [6:0] sr;
    logic [3:0] cnt;
    logic [TW-1:0] tmo, tmo_inc;
    logic fall, sample, last, timed_out;
    assign fall      = clk_prev & ~clk_sync[SYNC_STAGES-1];
    assign sample    = data_sync[SYNC_STAGES-1];
    assign last      = fall && cnt == 4'd7;
    assign tmo_inc   = tmo + TW'(1);
    assign timed_out = tmo_inc == TW'(TIMEOUT);
    always_ff @(posedge clk)
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:   state_nxt = (fall && sample) ? SHIFT : IDLE;
            SHIFT:  state_nxt = last ? STROBE : (!fall && timed_out) ? IDLE : SHIFT;
            STROBE: state_nxt = HOLD;
            HOLD:   state_nxt = ack ? IDLE : HOLD;
        endcase
    end
    always_comb begin
        irq         = state == STROBE || state == HOLD;
        kbd_inhibit = state == STROBE || state == HOLD;
        busy        = state == SHIFT;
    end
    // g is registered off STROBE so code has a full settled cycle before the latches load
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_sync  <= '1;
            data_sync <= '1;
            clk_prev  <= 1'b1;
            sr        <= '0;
            cnt       <= '0;
            tmo       <= '0;
            code      <= '0;
            g         <= 1'b0;
        end else begin
            clk_sync  <= {clk_sync[SYNC_STAGES-2:0], kbd_clk};
            data_sync <= {data_sync[SYNC_STAGES-2:0], kbd_data};
            clk_prev  <= clk_sync[SYNC_STAGES-1];
            g         <= state == STROBE;
            if (state == IDLE && fall && sample) begin
                cnt <= '0;
                tmo <= '0;
            end
            if (state == SHIFT) begin
                if (fall) begin
                    sr  <= {sample, sr[6:1]};
                    cnt <= cnt + 4'd1;
                    tmo <= '0;
                    if (last) code <= {sample, sr};
                end else begin
                    tmo <= timed_out ? tmo : tmo_inc;
                end
            end
        end
    end
endmodule

// File: tb/tb_kbd_scan_rx.sv
// tb_kbd_scan_rx: directed and randomized frames against a frame-level model of the receiver.
`timescale 1ns/1ps
module tb_kbd_scan_rx;
    localparam int TIMEOUT = 2000;
    logic clk = 1'b0, rst = 1'b1, kbd_clk = 1'b1, kbd_data = 1'b1, ack = 1'b0;
    logic [7:0] code;
    logic g, irq, kbd_inhibit, busy;
    int checks = 0, errors = 0;
    int cyc = 0, g_cnt = 0, g_cyc = 0, fall_cyc = 0, exp_g = 0;
    logic g_q = 1'b0, busy_seen = 1'b0, held = 1'b0;
    logic [7:0] code_q = 8'h00, code_before_g = 8'h00, exp_code = 8'h00;

    kbd_scan_rx dut (
        .clk(clk), .rst(rst), .kbd_clk(kbd_clk), .kbd_data(kbd_data), .ack(ack),
        .code(code), .g(g), .irq(irq), .kbd_inhibit(kbd_inhibit), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (g && !g_q) begin
            g_cyc = cyc;
            code_before_g = code_q;
        end
        if (g) g_cnt++;
        if (busy) busy_seen = 1'b1;
        g_q = g;
        code_q = code;
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_half(input bit rnd);
        repeat (rnd ? $urandom_range(12, 30) : 20) @(posedge clk);
        #1;
        if (rnd) #($urandom_range(0, 8));
    endtask

    // start bit followed by nbits data bits, LSB first; the model accepts it only when not holding a code
    task automatic send(input logic start, input logic [7:0] b, input int nbits, input bit rnd);
        for (int i = 0; i <= nbits; i++) begin
            kbd_data = (i == 0) ? start : b[i-1];
            wait_half(rnd);
            kbd_clk = 1'b0;
            fall_cyc = cyc;
            wait_half(rnd);
            kbd_clk = 1'b1;
        end
        if (nbits == 8 && start && !held) begin
            held = 1'b1;
            exp_code = b;
            exp_g++;
        end
    endtask

    task automatic do_ack();
        @(posedge clk); #1 ack = 1'b1;
        @(posedge clk); #1 ack = 1'b0;
        held = 1'b0;
        check("ack_irq", 32'(irq), 32'(0));
        check("ack_inhibit", 32'(kbd_inhibit), 32'(0));
    endtask

    task automatic check_frame(input string tag);
        repeat (4) @(posedge clk);
        #1;
        check({tag, "_code"}, 32'(code), 32'(exp_code));
        check({tag, "_gcnt"}, 32'(g_cnt), 32'(exp_g));
        check({tag, "_irq"}, 32'(irq), 32'(held));
        check({tag, "_busy"}, 32'(busy), 32'(0));
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_code", 32'(code), 32'(0));
        check("rst_g", 32'(g), 32'(0));
        check("rst_irq", 32'(irq), 32'(0));
        check("rst_inhibit", 32'(kbd_inhibit), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;

        send(1'b1, 8'h1C, 8, 1'b0);
        check_frame("f1c");
        check("f1c_inhibit", 32'(kbd_inhibit), 32'(1));
        check("f1c_latency", 32'(g_cyc - fall_cyc), 32'(4));
        check("f1c_code_before_g", 32'(code_before_g), 32'(8'h1C));

        send(1'b1, 8'hFF, 8, 1'b0);
        check_frame("hold_ff");
        check("hold_inhibit", 32'(kbd_inhibit), 32'(1));
        do_ack();
        check("ack_code_kept", 32'(code), 32'(8'h1C));
        send(1'b1, 8'hAA, 8, 1'b0);
        check_frame("faa");
        do_ack();

        busy_seen = 1'b0;
        send(1'b0, 8'h00, 8, 1'b0);
        check_frame("start0");
        check("start0_busy_seen", 32'(busy_seen), 32'(0));

        send(1'b1, 8'h0B, 4, 1'b0);
        while (cyc < fall_cyc + 2 + TIMEOUT) @(negedge clk);
        check("tmo_busy_before", 32'(busy), 32'(1));
        @(negedge clk);
        check("tmo_busy_after", 32'(busy), 32'(0));
        check_frame("tmo");
        send(1'b1, 8'h3A, 8, 1'b0);
        check_frame("f3a");
        do_ack();

        send(1'b1, 8'h15, 5, 1'b0);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1;
        check("mid_rst_code", 32'(code), 32'(0));
        check("mid_rst_busy", 32'(busy), 32'(0));
        check("mid_rst_irq", 32'(irq), 32'(0));
        check("mid_rst_g", 32'(g), 32'(0));
        rst = 1'b0;
        held = 1'b0;
        exp_code = 8'h00;
        busy_seen = 1'b0;
        send(1'b0, 8'h00, 2, 1'b0);
        check("rst_tail_busy_seen", 32'(busy_seen), 32'(0));
        check_frame("rst_tail");
        send(1'b1, 8'h01, 8, 1'b0);
        check_frame("f01");
        do_ack();

        for (int n = 0; n < 100; n++) begin
            send(1'b1, 8'($urandom_range(0, 255)), 8, 1'b1);
            check_frame("rnd");
            if ($urandom_range(0, 3) != 0) do_ack();
        end
        if (held) do_ack();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
